// File: rtl/pacman_move_if.sv
// Bundle of the frame/direction inputs, maze probe port and sprite status outputs
// shared by the Pac-Man movement controller and its environment.
interface pacman_move_if;
  logic       frame_tick;
  logic       dir_valid;
  logic [1:0] dir_req;
  logic [7:0] maze_b;
  logic [9:0] probe_x;
  logic [8:0] probe_y;
  logic [9:0] pac_x;
  logic [8:0] pac_y;
  logic [1:0] dir_cur;
  logic       moving;
  logic       busy;

  modport master (
    output frame_tick, dir_valid, dir_req, maze_b,
    input  probe_x, probe_y, pac_x, pac_y, dir_cur, moving, busy
  );

  modport slave (
    input  frame_tick, dir_valid, dir_req, maze_b,
    output probe_x, probe_y, pac_x, pac_y, dir_cur, moving, busy
  );
endinterface

// File: rtl/pacman_move_ctrl.sv
// Per-frame Pac-Man movement: probes the edge pixels ahead, then moves one pixel, falls back or stops.
// Optional feature: define PAC_TURN_BUFFER_EN to keep a blocked turn request pending across frames.
module pacman_move_ctrl #(
  parameter int MAZE_W  = 96,
  parameter int MAZE_H  = 72,
  parameter int SIZE    = 3,
  parameter int START_X = 6,
  parameter int START_Y = 6
) (
  input  logic         clk,
  input  logic         reset,
  pacman_move_if.slave bus
);
  typedef enum logic [1:0] {IDLE, PROBE_REQ, PROBE_CUR, COMMIT} state_t;

  localparam logic [1:0] DIR_RIGHT = 2'd0;
  localparam logic [1:0] DIR_LEFT  = 2'd1;
  localparam logic [1:0] DIR_UP    = 2'd2;
  localparam logic [1:0] DIR_DOWN  = 2'd3;

  localparam int              IDX_W    = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SIZE - 1);

  typedef struct packed {
    logic [9:0] x;
    logic [8:0] y;
    logic       oob;
  } pixel_t;

  // Coordinates are widened by one bit so that pac-1 at the origin goes negative instead of wrapping.
  function automatic pixel_t edge_pixel(input logic [1:0] dir, input logic [IDX_W-1:0] idx,
                                        input logic [9:0] px, input logic [8:0] py);
    logic [10:0] x;
    logic [9:0]  y;
    pixel_t      p;
    x = {1'b0, px};
    y = {1'b0, py};
    case (dir)
      DIR_RIGHT: begin x = x + 11'(SIZE); y = y + 10'(idx);  end
      DIR_LEFT:  begin x = x - 11'd1;     y = y + 10'(idx);  end
      DIR_UP:    begin x = x + 11'(idx);  y = y - 10'd1;     end
      default:   begin x = x + 11'(idx);  y = y + 10'(SIZE); end
    endcase
    p.x   = x[9:0];
    p.y   = y[8:0];
    p.oob = x[10] | y[9] | (x[9:0] >= 10'(MAZE_W)) | (y[8:0] >= 9'(MAZE_H));
    return p;
  endfunction

  state_t           state, state_n;
  logic [IDX_W-1:0] idx, idx_n;
  logic             blocked, blocked_n;
  logic [1:0]       try_dir, try_dir_n;
  logic             take_pend, take_pend_n;
  logic             pend_valid;
  logic [1:0]       pend_dir;
  logic [9:0]       probe_x, pac_x;
  logic [8:0]       probe_y, pac_y;
  logic             probe_oob;
  logic [1:0]       dir_cur;
  logic             moving;
  logic             hit, load_probe, do_commit, do_stop, pend_clr;
  pixel_t           probe_pix;

  assign hit = blocked | probe_oob | (bus.maze_b == 8'hFF);

  // NOTE: every variable gets a default before the case so no path can infer a latch.
  always_comb begin
    state_n     = state;
    idx_n       = idx;
    blocked_n   = blocked;
    try_dir_n   = try_dir;
    take_pend_n = take_pend;
    load_probe  = 1'b0;
    do_commit   = 1'b0;
    do_stop     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.frame_tick) begin
          idx_n      = '0;
          blocked_n  = 1'b0;
          load_probe = 1'b1;
          if (pend_valid && (pend_dir != dir_cur)) begin
            state_n     = PROBE_REQ;
            try_dir_n   = pend_dir;
            take_pend_n = 1'b1;
          end else begin
            state_n     = PROBE_CUR;
            try_dir_n   = dir_cur;
            take_pend_n = 1'b0;
          end
        end
      end
      PROBE_REQ, PROBE_CUR: begin
        if (idx != IDX_LAST) begin
          idx_n      = idx + IDX_W'(1);
          blocked_n  = hit;
          load_probe = 1'b1;
        end else if (!hit) begin
          state_n = COMMIT;
        end else if (state == PROBE_REQ) begin
          state_n     = PROBE_CUR;
          try_dir_n   = dir_cur;
          take_pend_n = 1'b0;
          idx_n       = '0;
          blocked_n   = 1'b0;
          load_probe  = 1'b1;
        end else begin
          state_n = IDLE;
          do_stop = 1'b1;
        end
      end
      default: begin
        state_n   = IDLE;
        do_commit = 1'b1;
      end
    endcase
    probe_pix = edge_pixel(try_dir_n, idx_n, pac_x, pac_y);
  end

`ifdef PAC_TURN_BUFFER_EN
  assign pend_clr = do_commit & take_pend;
`else
  assign pend_clr = do_commit | do_stop;
`endif

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      idx        <= '0;
      blocked    <= 1'b0;
      try_dir    <= DIR_RIGHT;
      take_pend  <= 1'b0;
      pend_valid <= 1'b0;
      pend_dir   <= DIR_RIGHT;
      probe_x    <= '0;
      probe_y    <= '0;
      probe_oob  <= 1'b0;
      pac_x      <= 10'(START_X);
      pac_y      <= 9'(START_Y);
      dir_cur    <= DIR_RIGHT;
      moving     <= 1'b0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      blocked   <= blocked_n;
      try_dir   <= try_dir_n;
      take_pend <= take_pend_n;
      if (load_probe) begin
        probe_x   <= probe_pix.x;
        probe_y   <= probe_pix.y;
        probe_oob <= probe_pix.oob;
      end
      if (do_commit) begin
        case (try_dir)
          DIR_RIGHT: pac_x <= pac_x + 10'd1;
          DIR_LEFT:  pac_x <= pac_x - 10'd1;
          DIR_UP:    pac_y <= pac_y - 9'd1;
          default:   pac_y <= pac_y + 9'd1;
        endcase
        dir_cur <= try_dir;
        moving  <= 1'b1;
      end
      if (do_stop) moving <= 1'b0;
      // A new request in the same cycle as a clear wins.
      if (bus.dir_valid) begin
        pend_valid <= 1'b1;
        pend_dir   <= bus.dir_req;
      end else if (pend_clr) begin
        pend_valid <= 1'b0;
      end
    end
  end

  assign bus.probe_x = probe_x;
  assign bus.probe_y = probe_y;
  assign bus.pac_x   = pac_x;
  assign bus.pac_y   = pac_y;
  assign bus.dir_cur = dir_cur;
  assign bus.moving  = moving;
  assign bus.busy    = (state != IDLE);
endmodule
